obi_slave: RTL and testbench
============================

OBI_SLAVE -- requirements
Module: obi_slave

Interface
Parameters:
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, OBI address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, OBI data width in bits (multiple of 8).
REQ-003 The block SHALL have parameter DEPTH, default 16, number of DATA_WIDTH-bit storage words (power of two).
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h0000, byte address of word 0.
REQ-005 The block SHALL have parameter LATENCY, default 1, cycles from request acceptance to rvalid (legal range 1..15).
Ports (one clock; reset is synchronous and active-high):
REQ-006 The block SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port obi_req_i, input, 1, master request.
REQ-009 The block SHALL have port obi_gnt_o, output, 1, grant.
REQ-010 The block SHALL have port obi_addr_i, input, ADDR_WIDTH, byte address.
REQ-011 The block SHALL have port obi_we_i, input, 1, 1 = write, 0 = read.
REQ-012 The block SHALL have port obi_be_i, input, DATA_WIDTH/8, byte enables.
REQ-013 The block SHALL have port obi_wdata_i, input, DATA_WIDTH, write data.
REQ-014 The block SHALL have port obi_rvalid_o, output, 1, response valid (one-cycle pulse).
REQ-015 The block SHALL have port obi_rdata_o, output, DATA_WIDTH, read data.

Function
REQ-016 The block SHALL accept a transaction in any cycle where obi_req_i and obi_gnt_o are both 1.
REQ-017 obi_gnt_o SHALL be combinational: obi_req_i AND (state == IDLE or state == RESP).
REQ-018 The FSM SHALL have states IDLE, WAIT, RESP: on accept, go to RESP if LATENCY == 1, else to WAIT; WAIT counts LATENCY-1 cycles, then goes to RESP; RESP goes to IDLE if there is no accept that cycle, otherwise re-enters the accept transition.
REQ-019 obi_rvalid_o SHALL be 1 exactly when state == RESP, i.e. exactly LATENCY cycles after the accept edge, for exactly one cycle per accepted transaction.
REQ-020 Word index SHALL be (obi_addr_i - BASE_ADDR) >> log2(DATA_WIDTH/8); low byte-offset bits are ignored; the address is in range iff obi_addr_i >= BASE_ADDR and index < DEPTH.
REQ-021 An in-range write SHALL update only the bytes with obi_be_i set, at the accept edge; bytes with obi_be_i clear keep their value.
REQ-022 A read SHALL capture the addressed word at the accept edge; obi_rdata_o SHALL present the captured word while obi_rvalid_o = 1 and SHALL be 0 otherwise.
REQ-023 Write responses SHALL assert obi_rvalid_o with obi_rdata_o = 0.
REQ-024 An out-of-range write SHALL be discarded, and an out-of-range read SHALL return 0; both SHALL still receive a normal response.
REQ-025 Maximum throughput SHALL be one transaction per LATENCY cycles (an accept in the RESP cycle overlaps the previous response).
REQ-026 While in WAIT, obi_gnt_o SHALL be 0 regardless of obi_req_i; a held request SHALL be accepted in the next RESP cycle.

Reset
REQ-027 While rst_i = 1 at a clock edge: state = IDLE, wait counter = 0, captured read data = 0, all storage words = 0.
REQ-028 After reset: obi_gnt_o = 0 (when obi_req_i = 0), obi_rvalid_o = 0, obi_rdata_o = 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no response; a write accepted at that same edge SHALL be lost.
REQ-030 obi_gnt_o SHALL be 0 while rst_i = 1.

Configuration
REQ-031 Macro OBI_SLAVE_ERR_EN SHALL, when defined, add output port obi_err_o (1 bit), equal to 1 with obi_rvalid_o for out-of-range transactions and 0 otherwise, reset 0.
REQ-032 When OBI_SLAVE_ERR_EN is undefined, port obi_err_o SHALL not exist, and out-of-range behaviour SHALL follow REQ-024 with no error indication.

Verification
REQ-033 The bench SHALL cover: reset, then write 32'hDEADBEEF to 0x0 with be=4'hF, then read 0x0 (LATENCY=1) -> each rvalid occurs 1 cycle after its accept, and the read returns 32'hDEADBEEF.
REQ-034 The bench SHALL cover: write 32'h11223344 with be=4'b0101 over 32'hDEADBEEF at 0x4, then read 0x4 -> 32'hDE22BE44.
REQ-035 The bench SHALL cover: with LATENCY=3, req held continuously for 4 reads -> gnt=0 during WAIT, rvalid exactly 3 cycles after each accept, accepts spaced 3 cycles apart.
REQ-036 The bench SHALL cover: read 0x40 with DEPTH=16 -> rdata=0, rvalid pulse, and obi_err_o=1 with OBI_SLAVE_ERR_EN defined; write 0x40 -> storage unchanged.
REQ-037 The bench SHALL cover: rst_i asserted in the WAIT cycle of a read -> no rvalid, state IDLE, prior writes read back as 0.
REQ-038 The bench SHALL cover: read 0x3 -> returns word 0 (byte-offset bits ignored).

Source files
------------

// File: rtl/obi_slave.sv
// OBI word-addressed RAM slave with configurable response latency.
// Optional OBI_SLAVE_ERR_EN adds obi_err_o for out-of-range accesses.
module obi_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000,
    parameter int          LATENCY    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o
`ifdef OBI_SLAVE_ERR_EN
    ,
    output logic                    obi_err_o
`endif
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam state_t ACC_STATE = (LATENCY == 1) ? RESP : WAIT;

    state_t                state, state_n;
    logic [3:0]            cnt, cnt_n;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic [IW-1:0]         idx;

    assign offset   = obi_addr_i - BASE;
    assign word     = offset >> OFF;
    assign in_range = (obi_addr_i >= BASE) && (word < ADDR_WIDTH'(DEPTH));
    assign idx      = word[IW-1:0];

    // Grant is suppressed during WAIT and while reset is asserted
    assign obi_gnt_o = obi_req_i && !rst_i && (state == IDLE || state == RESP);
    assign accept    = obi_gnt_o;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = ACC_STATE;
                    cnt_n   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            RESP: begin
                if (accept) begin
                    state_n = ACC_STATE;
                    cnt_n   = CNT_INIT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
        end else if (accept) begin
            rdata_q <= (!obi_we_i && in_range) ? mem[idx] : '0;
            if (obi_we_i && in_range) begin
                for (int b = 0; b < NB; b++) begin
                    if (obi_be_i[b]) mem[idx][b*8 +: 8] <= obi_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign obi_rvalid_o = (state == RESP);
    assign obi_rdata_o  = (state == RESP) ? rdata_q : '0;

`ifdef OBI_SLAVE_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)       err_q <= 1'b0;
        else if (accept) err_q <= !in_range;
    end

    assign obi_err_o = obi_rvalid_o && err_q;
`endif

endmodule

// File: tb/tb_obi_slave.sv
// Scoreboard bench for obi_slave: one LATENCY=1 and one LATENCY=3 instance.
// Define OBI_SLAVE_ERR_EN to also check obi_err_o.
module tb_obi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        sel;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        req1, gnt1, rv1;
    logic        req3, gnt3, rv3;
    logic [31:0] rd1, rd3;
    logic        err1, err3;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req1 = req && !sel;
    assign req3 = req && sel;

    obi_slave #(.LATENCY(1)) u_lat1 (
        .clk_i(clk), .rst_i(rst), .obi_req_i(req1), .obi_gnt_o(gnt1),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be),
        .obi_wdata_i(wdata), .obi_rvalid_o(rv1), .obi_rdata_o(rd1)
`ifdef OBI_SLAVE_ERR_EN
        , .obi_err_o(err1)
`endif
    );

    obi_slave #(.LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(rst), .obi_req_i(req3), .obi_gnt_o(gnt3),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be),
        .obi_wdata_i(wdata), .obi_rvalid_o(rv3), .obi_rdata_o(rd3)
`ifdef OBI_SLAVE_ERR_EN
        , .obi_err_o(err3)
`endif
    );

`ifndef OBI_SLAVE_ERR_EN
    assign err1 = 1'b0;
    assign err3 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat();
        return sel ? 3 : 1;
    endfunction

    task automatic clear_models();
        for (int m = 0; m < 2; m++)
            for (int w = 0; w < 16; w++) model[m][w] = '0;
    endtask

    // Drives one request (req left high) and records the expected response
    task automatic txn(input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d,
                       output int acc, output int waits);
        bit   got;
        bit   inr;
        int   m;
        exp_t e;
        logic [3:0] ix;
        got   = 0;
        waits = 0;
        acc   = 0;
        we    = w;
        addr  = a;
        be    = b;
        wdata = d;
        req   = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sel ? gnt3 : gnt1) begin
                got = 1;
                break;
            end
            waits++;
        end
        if (!got) begin
            check("gnt_timeout", 0, 1);
            req = 1'b0;
            return;
        end
        m   = sel ? 1 : 0;
        inr = (a < 32'h40);
        ix  = a[5:2];
        acc = cyc + 1;
        e.err = !inr;
        e.due = acc + lat() - 1;
        e.data = '0;
        if (w) begin
            if (inr)
                for (int k = 0; k < 4; k++)
                    if (b[k]) model[m][ix][k*8 +: 8] = d[k*8 +: 8];
        end else if (inr) begin
            e.data = model[m][ix];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sel ? rv3 : rv1) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rdata", sel ? rd3 : rd1, e.data);
                    check("rvalid_cycle", cyc, e.due);
`ifdef OBI_SLAVE_ERR_EN
                    check("err", sel ? err3 : err1, e.err);
`endif
                end
            end else begin
                check("rdata_idle", sel ? rd3 : rd1, 0);
            end
        end
    end

    initial begin
        int acc, waits, prev;
        rst   = 1'b1;
        req   = 1'b0;
        sel   = 1'b0;
        addr  = '0;
        we    = 1'b0;
        be    = '0;
        wdata = '0;
        clear_models();
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1;
        @(negedge clk);
        check("gnt_in_reset", gnt1, 0);
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", gnt1, 0);
        check("rst_rvalid", rv1, 0);
        check("rst_rdata", rd1, 0);
        @(posedge clk);
        #1;

        // LATENCY=1 instance
        txn(1, 32'h0, 4'hF, 32'hDEADBEEF, acc, waits);
        txn(0, 32'h0, 4'hF, 32'h0, acc, waits);
        idle(2);
        txn(1, 32'h4, 4'hF, 32'hDEADBEEF, acc, waits);
        txn(1, 32'h4, 4'b0101, 32'h11223344, acc, waits);
        txn(0, 32'h4, 4'hF, 32'h0, acc, waits);
        idle(2);
        txn(0, 32'h40, 4'hF, 32'h0, acc, waits);
        txn(1, 32'h40, 4'hF, 32'hFFFFFFFF, acc, waits);
        txn(0, 32'h0, 4'hF, 32'h0, acc, waits);
        txn(0, 32'h4, 4'hF, 32'h0, acc, waits);
        txn(0, 32'h3, 4'hF, 32'h0, acc, waits);
        idle(3);

        // LATENCY=3 instance
        sel = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++)
            txn(1, 32'(i * 4), 4'hF, 32'hA5A50000 + 32'(i), acc, waits);
        idle(6);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            txn(0, 32'(i * 4), 4'hF, 32'h0, acc, waits);
            if (i > 0) begin
                check("acc_spacing", acc - prev, 3);
                check("gnt_low_in_wait", waits, 2);
            end
            prev = acc;
        end
        idle(6);

        // Reset during the WAIT phase of a read
        txn(0, 32'h8, 4'hF, 32'h0, acc, waits);
        rst = 1'b1;
        req = 1'b0;
        sb.delete();
        clear_models();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_gnt", gnt3, 0);
        check("abort_rvalid", rv3, 0);
        check("abort_rdata", rd3, 0);
        idle(5);
        txn(0, 32'h8, 4'hF, 32'h0, acc, waits);
        txn(0, 32'h0, 4'hF, 32'h0, acc, waits);
        idle(6);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
